// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: accepts one instruction per handshake, decodes it,
// and sequences DECODE/EXEC/MEM/WB while driving register-file, ALU and memory controls.
`timescale 1ns/1ps

module multicycle_ctrl #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned LOAD_LAT      = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              instr,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic                     eq,
    output logic [ADDRESS_WIDTH-1:0] rs1,
    output logic [ADDRESS_WIDTH-1:0] rs2,
    output logic [ADDRESS_WIDTH-1:0] rd,
    output logic                     RegWrite,
    output logic                     ALUsrc,
    output logic                     ResultSrc,
    output logic                     MemWrite,
    output logic [2:0]               ALUCtrl,
    output logic [DATA_WIDTH-1:0]    ImmOp,
    output logic                     br_taken,
    output logic                     done,
    output logic                     illegal
);

    localparam int unsigned CNT_W = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    typedef enum logic [2:0] {
        K_ALU_R,
        K_ALU_I,
        K_LW,
        K_SW,
        K_BEQ,
        K_BNE,
        K_BAD
    } kind_t;

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        ir;
    logic [31:0]        ir_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;

    logic [31:0]        dec_word;
    logic [6:0]         dec_op;
    logic [2:0]         dec_f3;
    logic [6:0]         dec_f7;
    logic [31:0]        imm_i;
    logic [31:0]        imm_s;
    logic [31:0]        imm_b;
    kind_t              dec_kind;
    logic [2:0]         dec_alu;
    logic               dec_alusrc;
    logic [31:0]        dec_imm;

    logic                     go_idle;
    logic                     instr_ready_nxt;
    logic [ADDRESS_WIDTH-1:0] rs1_nxt;
    logic [ADDRESS_WIDTH-1:0] rs2_nxt;
    logic [ADDRESS_WIDTH-1:0] rd_nxt;
    logic                     reg_write_nxt;
    logic                     alu_src_nxt;
    logic                     result_src_nxt;
    logic                     mem_write_nxt;
    logic [2:0]               alu_ctrl_nxt;
    logic [DATA_WIDTH-1:0]    imm_nxt;
    logic                     br_taken_nxt;
    logic                     done_nxt;
    logic                     illegal_nxt;

    // Decode the live word while accepting, the latched word afterwards
    assign dec_word = (state == S_IDLE) ? instr : ir;
    assign dec_op   = dec_word[6:0];
    assign dec_f3   = dec_word[14:12];
    assign dec_f7   = dec_word[31:25];

    // Sign-extended immediate formats
    assign imm_i = {{20{dec_word[31]}}, dec_word[31:20]};
    assign imm_s = {{20{dec_word[31]}}, dec_word[31:25], dec_word[11:7]};
    assign imm_b = {{19{dec_word[31]}}, dec_word[31], dec_word[7], dec_word[30:25],
                    dec_word[11:8], 1'b0};

    // Classify the instruction and derive ALU control, operand select and immediate
    always_comb begin
        dec_kind   = K_BAD;
        dec_alu    = ALU_ADD;
        dec_alusrc = 1'b0;
        dec_imm    = '0;
        case (dec_op)
            OP_R: begin
                if (dec_f7 == 7'b0000000) begin
                    case (dec_f3)
                        3'b000:  begin dec_kind = K_ALU_R; dec_alu = ALU_ADD; end
                        3'b111:  begin dec_kind = K_ALU_R; dec_alu = ALU_AND; end
                        3'b110:  begin dec_kind = K_ALU_R; dec_alu = ALU_OR;  end
                        3'b010:  begin dec_kind = K_ALU_R; dec_alu = ALU_SLT; end
                        default: dec_kind = K_BAD;
                    endcase
                end else if (dec_f7 == 7'b0100000 && dec_f3 == 3'b000) begin
                    dec_kind = K_ALU_R;
                    dec_alu  = ALU_SUB;
                end
            end
            OP_I: begin
                dec_alusrc = 1'b1;
                dec_imm    = imm_i;
                case (dec_f3)
                    3'b000:  begin dec_kind = K_ALU_I; dec_alu = ALU_ADD; end
                    3'b111:  begin dec_kind = K_ALU_I; dec_alu = ALU_AND; end
                    3'b110:  begin dec_kind = K_ALU_I; dec_alu = ALU_OR;  end
                    3'b010:  begin dec_kind = K_ALU_I; dec_alu = ALU_SLT; end
                    default: dec_kind = K_BAD;
                endcase
            end
            OP_LOAD: begin
                dec_alusrc = 1'b1;
                dec_imm    = imm_i;
                if (dec_f3 == 3'b010) begin
                    dec_kind = K_LW;
                end
            end
            OP_STORE: begin
                dec_alusrc = 1'b1;
                dec_imm    = imm_s;
                if (dec_f3 == 3'b010) begin
                    dec_kind = K_SW;
                end
            end
            OP_BRANCH: begin
                dec_alu = ALU_SUB;
                dec_imm = imm_b;
                case (dec_f3)
                    3'b000:  dec_kind = K_BEQ;
                    3'b001:  dec_kind = K_BNE;
                    default: dec_kind = K_BAD;
                endcase
            end
            default: dec_kind = K_BAD;
        endcase
    end

    // State register and in-flight bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ir    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            ir    <= ir_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state and next value of every registered output
    always_comb begin
        state_nxt       = state;
        ir_nxt          = ir;
        cnt_nxt         = cnt;
        go_idle         = 1'b0;
        instr_ready_nxt = 1'b0;
        rs1_nxt         = rs1;
        rs2_nxt         = rs2;
        rd_nxt          = rd;
        alu_src_nxt     = ALUsrc;
        alu_ctrl_nxt    = ALUCtrl;
        imm_nxt         = ImmOp;
        reg_write_nxt   = 1'b0;
        result_src_nxt  = 1'b0;
        mem_write_nxt   = 1'b0;
        br_taken_nxt    = 1'b0;
        done_nxt        = 1'b0;
        illegal_nxt     = 1'b0;

        case (state)
            S_IDLE: begin
                if (instr_valid) begin
                    ir_nxt    = instr;
                    state_nxt = S_DECODE;
                    if (dec_kind == K_BAD) begin
                        illegal_nxt = 1'b1;
                    end else begin
                        rs1_nxt      = ADDRESS_WIDTH'(instr[19:15]);
                        rs2_nxt      = ADDRESS_WIDTH'(instr[24:20]);
                        rd_nxt       = ADDRESS_WIDTH'(instr[11:7]);
                        alu_ctrl_nxt = dec_alu;
                        alu_src_nxt  = dec_alusrc;
                        imm_nxt      = DATA_WIDTH'(dec_imm);
                    end
                end else begin
                    go_idle = 1'b1;
                end
            end
            S_DECODE: begin
                if (dec_kind == K_BAD) begin
                    go_idle = 1'b1;
                end else begin
                    state_nxt = S_EXEC;
                    // Operands have been stable since accept, so eq is settled here
                    if (dec_kind == K_BEQ) begin
                        br_taken_nxt = eq;
                        done_nxt     = 1'b1;
                    end else if (dec_kind == K_BNE) begin
                        br_taken_nxt = ~eq;
                        done_nxt     = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                case (dec_kind)
                    K_LW: begin
                        state_nxt      = S_MEM;
                        result_src_nxt = 1'b1;
                        cnt_nxt        = CNT_W'(LOAD_LAT - 1);
                    end
                    K_SW: begin
                        state_nxt     = S_MEM;
                        mem_write_nxt = 1'b1;
                        done_nxt      = 1'b1;
                    end
                    K_ALU_R, K_ALU_I: begin
                        state_nxt     = S_WB;
                        reg_write_nxt = (rd != '0);
                        done_nxt      = 1'b1;
                    end
                    default: go_idle = 1'b1;
                endcase
            end
            S_MEM: begin
                if (dec_kind == K_LW) begin
                    result_src_nxt = 1'b1;
                    if (cnt == '0) begin
                        state_nxt     = S_WB;
                        reg_write_nxt = (rd != '0);
                        done_nxt      = 1'b1;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end else begin
                    go_idle = 1'b1;
                end
            end
            S_WB:    go_idle = 1'b1;
            default: go_idle = 1'b1;
        endcase

        // Returning to IDLE clears the decoded fields and reopens the handshake
        if (go_idle) begin
            state_nxt       = S_IDLE;
            instr_ready_nxt = 1'b1;
            rs1_nxt         = '0;
            rs2_nxt         = '0;
            rd_nxt          = '0;
            alu_src_nxt     = 1'b0;
            alu_ctrl_nxt    = ALU_ADD;
            imm_nxt         = '0;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_ready <= 1'b1;
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            RegWrite    <= 1'b0;
            ALUsrc      <= 1'b0;
            ResultSrc   <= 1'b0;
            MemWrite    <= 1'b0;
            ALUCtrl     <= '0;
            ImmOp       <= '0;
            br_taken    <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            instr_ready <= instr_ready_nxt;
            rs1         <= rs1_nxt;
            rs2         <= rs2_nxt;
            rd          <= rd_nxt;
            RegWrite    <= reg_write_nxt;
            ALUsrc      <= alu_src_nxt;
            ResultSrc   <= result_src_nxt;
            MemWrite    <= mem_write_nxt;
            ALUCtrl     <= alu_ctrl_nxt;
            ImmOp       <= imm_nxt;
            br_taken    <= br_taken_nxt;
            done        <= done_nxt;
            illegal     <= illegal_nxt;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instructions push expected retire
// records; a negedge monitor tracks each in-flight instruction and compares on retire.
`timescale 1ns/1ps

module tb_multicycle_ctrl;

    localparam int unsigned LOAD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        eq;
    logic [4:0]  rs1, rs2, rd;
    logic        RegWrite, ALUsrc, ResultSrc, MemWrite;
    logic [2:0]  ALUCtrl;
    logic [31:0] ImmOp;
    logic        br_taken, done, illegal;

    always #5 clk = ~clk;

    multicycle_ctrl #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5), .LOAD_LAT(LOAD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .eq(eq), .rs1(rs1), .rs2(rs2), .rd(rd),
        .RegWrite(RegWrite), .ALUsrc(ALUsrc), .ResultSrc(ResultSrc), .MemWrite(MemWrite),
        .ALUCtrl(ALUCtrl), .ImmOp(ImmOp), .br_taken(br_taken), .done(done),
        .illegal(illegal)
    );

    typedef struct {
        string       name;
        bit          ill;
        int          lat;
        logic [31:0] imm;
        bit          chk_rd;
        logic [4:0]  rd;
        logic [2:0]  alu;
        bit          alusrc;
        int          nreg;
        int          nmem;
        int          nres;
        int          nbr;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   tests = 0, fails = 0;
    int   stray = 0, ready_bad = 0, overlap = 0, accepts = 0, retires = 0, issued = 0;
    bit   busy = 0, chk_ready = 0;
    int   cyc, c_reg, c_mem, c_res, c_br;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic exp_t e_base(input string nm);
        exp_t r;
        r.name = nm; r.ill = 0; r.lat = 0; r.imm = '0; r.chk_rd = 0; r.rd = '0;
        r.alu = 3'b000; r.alusrc = 0; r.nreg = 0; r.nmem = 0; r.nres = 0; r.nbr = 0;
        return r;
    endfunction

    function automatic exp_t e_alu(input string nm, input logic [31:0] imm,
                                   input logic [4:0] rdv, input logic [2:0] alu,
                                   input bit alusrc, input int nreg);
        exp_t r = e_base(nm);
        r.lat = 3; r.imm = imm; r.chk_rd = 1; r.rd = rdv; r.alu = alu;
        r.alusrc = alusrc; r.nreg = nreg;
        return r;
    endfunction

    function automatic exp_t e_lw(input string nm, input logic [31:0] imm,
                                  input logic [4:0] rdv);
        exp_t r = e_base(nm);
        r.lat = 3 + LOAD_LAT; r.imm = imm; r.chk_rd = 1; r.rd = rdv; r.alusrc = 1;
        r.nreg = 1; r.nres = LOAD_LAT + 1;
        return r;
    endfunction

    function automatic exp_t e_sw(input string nm, input logic [31:0] imm);
        exp_t r = e_base(nm);
        r.lat = 3; r.imm = imm; r.alusrc = 1; r.nmem = 1;
        return r;
    endfunction

    function automatic exp_t e_br(input string nm, input logic [31:0] imm, input int taken);
        exp_t r = e_base(nm);
        r.lat = 2; r.imm = imm; r.alu = 3'b001; r.nbr = taken;
        return r;
    endfunction

    function automatic exp_t e_ill(input string nm);
        exp_t r = e_base(nm);
        r.ill = 1; r.lat = 1;
        return r;
    endfunction

    // Monitor: follow each accepted instruction and score it when it retires
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            busy = 0;
            chk_ready = 0;
        end else begin
            if (chk_ready) begin
                check("ready_after_retire", 32'(instr_ready), 32'd1);
                chk_ready = 0;
            end
            if (busy) begin
                cyc++;
                if (RegWrite)  c_reg++;
                if (MemWrite)  c_mem++;
                if (ResultSrc) c_res++;
                if (br_taken)  c_br++;
                if (RegWrite && MemWrite) overlap++;
                if (instr_ready) ready_bad++;
                if (done || illegal) begin
                    retires++;
                    if (q.size() == 0) begin
                        check("unexpected_retire", 32'(done | illegal), 32'd0);
                    end else begin
                        e = q.pop_front();
                        check({e.name, ".illegal"}, 32'(illegal), 32'(e.ill));
                        check({e.name, ".done"}, 32'(done), 32'(!e.ill));
                        check({e.name, ".latency"}, 32'(cyc), 32'(e.lat));
                        check({e.name, ".regwrite_cycles"}, 32'(c_reg), 32'(e.nreg));
                        check({e.name, ".memwrite_cycles"}, 32'(c_mem), 32'(e.nmem));
                        check({e.name, ".resultsrc_cycles"}, 32'(c_res), 32'(e.nres));
                        check({e.name, ".br_taken_cycles"}, 32'(c_br), 32'(e.nbr));
                        if (!e.ill) begin
                            check({e.name, ".ImmOp"}, ImmOp, e.imm);
                            check({e.name, ".ALUCtrl"}, 32'(ALUCtrl), 32'(e.alu));
                            check({e.name, ".ALUsrc"}, 32'(ALUsrc), 32'(e.alusrc));
                            if (e.chk_rd) check({e.name, ".rd"}, 32'(rd), 32'(e.rd));
                        end
                    end
                    busy = 0;
                    chk_ready = 1;
                end
            end else if (RegWrite | MemWrite | done | illegal | br_taken | ResultSrc) begin
                stray++;
            end
            if (!busy && instr_valid && instr_ready) begin
                busy = 1; accepts++; cyc = 0;
                c_reg = 0; c_mem = 0; c_res = 0; c_br = 0;
            end
        end
    end

    // Present a word until it is accepted; called and returning #1 after a rising edge
    task automatic issue(input logic [31:0] w, input exp_t ex, input bit keep);
        bit got = 0;
        q.push_back(ex);
        issued++;
        instr = w;
        instr_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (instr_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) check({ex.name, ".accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (!keep) instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit got = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (instr_ready && !busy) begin
                got = 1;
                break;
            end
        end
        if (!got) check("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run1(input logic [31:0] w, input exp_t ex, input logic eqv);
        eq = eqv;
        issue(w, ex, 1'b0);
        wait_idle();
    endtask

    initial begin
        int bad;
        instr = '0;
        instr_valid = 1'b0;
        eq = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset.instr_ready", 32'(instr_ready), 32'd1);
        check("reset.strobes", 32'({RegWrite, MemWrite, done, illegal, br_taken}), 32'd0);
        check("reset.controls", 32'({ALUsrc, ResultSrc, ALUCtrl}), 32'd0);
        check("reset.regs", 32'({rs1, rs2, rd}), 32'd0);
        check("reset.ImmOp", ImmOp, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed single instructions
        run1(32'h00500093, e_alu("addi_x1_5", 32'd5, 5'd1, 3'b000, 1, 1), 1'b0);
        run1(32'h00102423, e_sw("sw_x1_8", 32'd8), 1'b0);
        run1(32'h00802103, e_lw("lw_x2_8", 32'd8, 5'd2), 1'b0);
        run1(32'hFE000EE3, e_br("beq_eq1", 32'hFFFF_FFFC, 1), 1'b1);
        run1(32'hFE000EE3, e_br("beq_eq0", 32'hFFFF_FFFC, 0), 1'b0);
        run1(32'hFE001EE3, e_br("bne_eq1", 32'hFFFF_FFFC, 0), 1'b1);
        run1(32'hFE001EE3, e_br("bne_eq0", 32'hFFFF_FFFC, 1), 1'b0);
        run1(32'h00108033, e_alu("add_x0", 32'd0, 5'd0, 3'b000, 0, 0), 1'b0);
        run1(32'h0000007F, e_ill("op_7f"), 1'b0);
        run1(32'h402081B3, e_alu("sub_x3", 32'd0, 5'd3, 3'b001, 0, 1), 1'b0);
        run1(32'h0020F233, e_alu("and_x4", 32'd0, 5'd4, 3'b010, 0, 1), 1'b0);
        run1(32'h0020E2B3, e_alu("or_x5", 32'd0, 5'd5, 3'b011, 0, 1), 1'b0);
        run1(32'h0020A333, e_alu("slt_x6", 32'd0, 5'd6, 3'b101, 0, 1), 1'b0);
        run1(32'hFFF0A393, e_alu("slti_m1", 32'hFFFF_FFFF, 5'd7, 3'b101, 1, 1), 1'b0);
        run1(32'h7FF0F413, e_alu("andi_7ff", 32'h0000_07FF, 5'd8, 3'b010, 1, 1), 1'b0);
        run1(32'h80006493, e_alu("ori_m2048", 32'hFFFF_F800, 5'd9, 3'b011, 1, 1), 1'b0);
        run1(32'hFE20AE23, e_sw("sw_m4", 32'hFFFF_FFFC), 1'b0);
        run1(32'h4020F233, e_ill("bad_f7_and"), 1'b0);
        run1(32'h00800103, e_ill("lb_unsupported"), 1'b0);
        run1(32'hFE004EE3, e_ill("blt_unsupported"), 1'b0);

        // instr_valid held high across a burst; words change while the FSM is busy
        eq = 1'b0;
        issue(32'h00500093, e_alu("b2b_addi", 32'd5, 5'd1, 3'b000, 1, 1), 1'b1);
        issue(32'h402081B3, e_alu("b2b_sub", 32'd0, 5'd3, 3'b001, 0, 1), 1'b1);
        issue(32'h00102423, e_sw("b2b_sw", 32'd8), 1'b1);
        issue(32'h00802103, e_lw("b2b_lw", 32'd8, 5'd2), 1'b1);
        issue(32'h0000007F, e_ill("b2b_ill"), 1'b1);
        issue(32'h00108033, e_alu("b2b_add_x0", 32'd0, 5'd0, 3'b000, 0, 0), 1'b0);
        wait_idle();

        // Reset while a load sits in MEM
        issue(32'h00802103, e_lw("lw_killed", 32'd8, 5'd2), 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset.instr_ready", 32'(instr_ready), 32'd1);
        check("midreset.strobes", 32'({RegWrite, MemWrite, done, ResultSrc}), 32'd0);
        check("midreset.fields", 32'({rd, ALUsrc, ALUCtrl}), 32'd0);
        check("midreset.ImmOp", ImmOp, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (RegWrite || MemWrite || done) bad++;
        end
        check("midreset.no_late_strobe", 32'(bad), 32'd0);
        @(posedge clk);
        #1;
        run1(32'h00500093, e_alu("post_reset_addi", 32'd5, 5'd1, 3'b000, 1, 1), 1'b0);

        // Drain and global invariants
        bad = 1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) begin
                bad = 0;
                break;
            end
        end
        check("drain_timeout", 32'(bad), 32'd0);
        check("stray_strobes", 32'(stray), 32'd0);
        check("regwrite_memwrite_overlap", 32'(overlap), 32'd0);
        check("ready_while_busy", 32'(ready_bad), 32'd0);
        check("accept_count", 32'(accepts), 32'(issued));
        check("retire_count", 32'(retires), 32'(issued - 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

endmodule
